bsg_wormhole_dma_initiator: RTL and testbench

- Vcache-side DMA-to-wormhole adapter. It is the initiator end of the wormhole memory link that the wormhole test memory answers.
- Accepts one block-sized DMA read or write request at a time and serialises it into wormhole flits: header, address, then write data.
- Parses the memory's response flits and returns read data or a write acknowledgement.
- Sits between a vcache DMA port and one input of the wormhole concentrator.

---
 rtl/bsg_wormhole_dma_initiator.sv | 240 ++++++++++++++++++++++++
 tb/tb_bsg_wormhole_dma_initiator.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_wormhole_dma_initiator.sv
// Vcache-side DMA-to-wormhole initiator. A block read or write request is
// serialised into header/address/data flits on the outgoing link, and the
// memory's response (read data or a zero-length write ack) is parsed back
// into the DMA read-data port or a one-cycle write-ack pulse.
module bsg_wormhole_dma_initiator #(
  parameter int flit_width_p = 32,
  parameter int cord_width_p = 7,
  parameter int len_width_p  = 4,
  parameter int cid_width_p  = 5,
  parameter int addr_width_p = 32,
  parameter int data_flits_p = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_i,

  input  logic [cord_width_p-1:0]   dest_cord_i,
  input  logic [cid_width_p-1:0]    my_cid_i,

  input  logic                      dma_pkt_v_i,
  input  logic                      dma_pkt_write_not_read_i,
  input  logic [addr_width_p-1:0]   dma_pkt_addr_i,
  output logic                      dma_pkt_yumi_o,

  input  logic                      dma_data_v_i,
  input  logic [flit_width_p-1:0]   dma_data_i,
  output logic                      dma_data_yumi_o,

  output logic                      dma_data_v_o,
  output logic [flit_width_p-1:0]   dma_data_o,
  input  logic                      dma_data_ready_i,

  output logic                      wr_ack_v_o,

  input  logic [flit_width_p+1:0]   wh_link_sif_i,
  output logic [flit_width_p+1:0]   wh_link_sif_o
);

  // Header field positions: cord | len | cid | write_not_read | zeros
  localparam int hdr_len_lsb_lp  = cord_width_p;
  localparam int hdr_cid_lsb_lp  = cord_width_p + len_width_p;
  localparam int hdr_wnr_lsb_lp  = cord_width_p + len_width_p + cid_width_p;
  localparam int tx_cnt_width_lp = $clog2(data_flits_p + 1);

  localparam logic [len_width_p-1:0] rd_req_len_lp = len_width_p'(1);
  localparam logic [len_width_p-1:0] wr_req_len_lp = len_width_p'(data_flits_p + 1);
  localparam logic [len_width_p-1:0] rd_rsp_len_lp = len_width_p'(data_flits_p);
  localparam logic [len_width_p-1:0] wr_rsp_len_lp = '0;

  localparam logic [tx_cnt_width_lp-1:0] tx_cnt_last_lp =
    tx_cnt_width_lp'(data_flits_p - 1);

  localparam logic [2:0] TX_IDLE = 3'd0;
  localparam logic [2:0] TX_HDR  = 3'd1;
  localparam logic [2:0] TX_ADDR = 3'd2;
  localparam logic [2:0] TX_DATA = 3'd3;
  localparam logic [2:0] TX_WAIT = 3'd4;

  localparam logic [0:0] R_HDR  = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  // Incoming link fields
  logic                    in_v;
  logic [flit_width_p-1:0] in_data;
  logic                    in_ready;
  logic [len_width_p-1:0]  rx_len;

  assign in_v     = wh_link_sif_i[flit_width_p+1];
  assign in_data  = wh_link_sif_i[flit_width_p:1];
  assign in_ready = wh_link_sif_i[0];
  assign rx_len   = in_data[hdr_len_lsb_lp +: len_width_p];

  // State and capture registers
  logic [2:0]                 tx_state_q, tx_state_d;
  logic [tx_cnt_width_lp-1:0] tx_cnt_q, tx_cnt_d;
  logic [0:0]                 rx_state_q, rx_state_d;
  logic [len_width_p-1:0]     rx_cnt_q, rx_cnt_d;
  logic                       wr_ack_q, wr_ack_d;

  logic [addr_width_p-1:0]    addr_q;
  logic                       wnr_q;
  logic [cord_width_p-1:0]    cord_q;
  logic [cid_width_p-1:0]     cid_q;

  // Internal (ungated) handshake signals
  logic                    out_v;
  logic [flit_width_p-1:0] out_data;
  logic                    rx_ready;
  logic                    pkt_yumi;
  logic                    data_yumi;
  logic                    rd_v;
  logic [flit_width_p-1:0] rd_data;
  logic                    rx_done;
  logic                    rsp_type_ok;

  logic [flit_width_p-1:0] hdr_flit;
  logic [flit_width_p-1:0] addr_flit;

  // Build the request header from the captured request fields
  always_comb begin
    hdr_flit = '0;
    hdr_flit[cord_width_p-1:0]                  = cord_q;
    hdr_flit[hdr_len_lsb_lp +: len_width_p]     = wnr_q ? wr_req_len_lp : rd_req_len_lp;
    hdr_flit[hdr_cid_lsb_lp +: cid_width_p]     = cid_q;
    hdr_flit[hdr_wnr_lsb_lp]                    = wnr_q;
  end

  assign addr_flit = flit_width_p'(addr_q);

  // A response is only legal while a request waits, and its length must
  // match the outstanding request type.
  assign rsp_type_ok = (tx_state_q == TX_WAIT)
                    && (wnr_q ? (rx_len == wr_rsp_len_lp) : (rx_len == rd_rsp_len_lp));

  // TX FSM: accept request, then emit header, address and write data
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    out_v      = 1'b0;
    out_data   = '0;
    pkt_yumi   = 1'b0;
    data_yumi  = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        pkt_yumi = dma_pkt_v_i;
        if (dma_pkt_v_i) tx_state_d = TX_HDR;
      end
      TX_HDR: begin
        out_v    = 1'b1;
        out_data = hdr_flit;
        if (in_ready) tx_state_d = TX_ADDR;
      end
      TX_ADDR: begin
        out_v    = 1'b1;
        out_data = addr_flit;
        if (in_ready) tx_state_d = wnr_q ? TX_DATA : TX_WAIT;
      end
      TX_DATA: begin
        out_v     = dma_data_v_i;
        out_data  = dma_data_i;
        data_yumi = dma_data_v_i & in_ready;
        if (data_yumi) begin
          if (tx_cnt_q == tx_cnt_last_lp) begin
            tx_cnt_d   = '0;
            tx_state_d = TX_WAIT;
          end else begin
            tx_cnt_d = tx_cnt_q + 1'b1;
          end
        end
      end
      TX_WAIT: begin
        if (rx_done) tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // RX FSM: parse response header, stream read data, flag write ack
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_ready   = 1'b0;
    rd_v       = 1'b0;
    rd_data    = '0;
    rx_done    = 1'b0;
    wr_ack_d   = 1'b0;
    if (rx_state_q == R_HDR) begin
      rx_ready = 1'b1;
      // Unexpected or mistyped headers are consumed and dropped
      if (in_v && rsp_type_ok) begin
        if (rx_len == '0) begin
          rx_done  = 1'b1;
          wr_ack_d = 1'b1;
        end else begin
          rx_cnt_d   = rx_len;
          rx_state_d = R_DATA;
        end
      end
    end else begin
      rx_ready = dma_data_ready_i;
      rd_v     = in_v;
      rd_data  = in_data;
      if (in_v && dma_data_ready_i) begin
        rx_cnt_d = rx_cnt_q - 1'b1;
        if (rx_cnt_q == len_width_p'(1)) begin
          rx_done    = 1'b1;
          rx_state_d = R_HDR;
        end
      end
    end
  end

  // State registers; synchronous active-low reset aborts any packet
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      rx_state_q <= R_HDR;
      rx_cnt_q   <= '0;
      wr_ack_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      wr_ack_q   <= wr_ack_d;
    end
  end

  // Capture request fields at accept
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      addr_q <= '0;
      wnr_q  <= 1'b0;
      cord_q <= '0;
      cid_q  <= '0;
    end else if (pkt_yumi) begin
      addr_q <= dma_pkt_addr_i;
      wnr_q  <= dma_pkt_write_not_read_i;
      cord_q <= dest_cord_i;
      cid_q  <= my_cid_i;
    end
  end

  // Outputs forced to zero while reset is held low
  assign wh_link_sif_o   = reset_i ? {out_v, out_data, rx_ready} : '0;
  assign dma_pkt_yumi_o  = reset_i & pkt_yumi;
  assign dma_data_yumi_o = reset_i & data_yumi;
  assign dma_data_v_o    = reset_i & rd_v;
  assign dma_data_o      = reset_i ? rd_data : '0;
  assign wr_ack_v_o      = reset_i & wr_ack_q;

  // Flag response headers that arrive unsolicited or with the wrong length
  always_ff @(posedge clk_i) begin
    if (reset_i && (rx_state_q == R_HDR) && in_v) begin
      rsp_unsolicited_a: assert (tx_state_q == TX_WAIT);
      rsp_type_a:        assert ((tx_state_q != TX_WAIT) || rsp_type_ok);
    end
  end

endmodule

// File: tb/tb_bsg_wormhole_dma_initiator.sv
// Directed bench for bsg_wormhole_dma_initiator. A small memory-side model
// answers every complete request: reads get a len=8 header plus words from
// rd_next upward, writes get a len=0 header. Expected headers are computed by
// hand: read  = cord 0x1F | len 1 << 7 | cid 3 << 11            = 0x0000_189F
//       write = cord 0x1F | len 9 << 7 | cid 3 << 11 | 1 << 16  = 0x0001_1C9F
module tb_bsg_wormhole_dma_initiator;

  localparam logic [31:0] RD_HDR = 32'h0000_189F;
  localparam logic [31:0] WR_HDR = 32'h0001_1C9F;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_i;
  logic [6:0]  dest_cord;
  logic [4:0]  my_cid;
  logic        pkt_v, pkt_wnr, pkt_yumi;
  logic [31:0] pkt_addr;
  logic        wd_v, wd_yumi;
  logic [31:0] wd;
  logic        rd_v, rd_ready, wr_ack;
  logic [31:0] rd;
  logic        in_v, in_rdy;
  logic [31:0] in_data;
  logic [33:0] wh_i, wh_o;
  logic        out_v, out_rdy;
  logic [31:0] out_data;

  assign wh_i     = {in_v, in_data, in_rdy};
  assign out_v    = wh_o[33];
  assign out_data = wh_o[32:1];
  assign out_rdy  = wh_o[0];

  bsg_wormhole_dma_initiator #(
    .flit_width_p(32), .cord_width_p(7), .len_width_p(4),
    .cid_width_p(5), .addr_width_p(32), .data_flits_p(8)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .dest_cord_i(dest_cord), .my_cid_i(my_cid),
    .dma_pkt_v_i(pkt_v), .dma_pkt_write_not_read_i(pkt_wnr),
    .dma_pkt_addr_i(pkt_addr), .dma_pkt_yumi_o(pkt_yumi),
    .dma_data_v_i(wd_v), .dma_data_i(wd), .dma_data_yumi_o(wd_yumi),
    .dma_data_v_o(rd_v), .dma_data_o(rd), .dma_data_ready_i(rd_ready),
    .wr_ack_v_o(wr_ack),
    .wh_link_sif_i(wh_i), .wh_link_sif_o(wh_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] out_q[$], rd_q[$], rsp_q[$], wr_src[$], req_addr[$];
  logic        req_wnr[$];
  int          wr_idx = 0;
  int          n_pkt = 0, n_wyumi = 0, n_ack = 0, overlap_cnt = 0;
  bit          outstanding = 0, rdy_rand = 0, sink_rand = 0;
  bit          stall_prev = 0;
  logic [31:0] stall_data;
  logic [31:0] rd_next = '0;
  int          m_idx = 0;
  logic [3:0]  m_len;
  logic        m_wnr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory-side model: once a whole request has left the DUT, queue a response
  task automatic model_tx(input logic [31:0] flit);
    if (m_idx == 0) begin
      m_len = flit[10:7];
      m_wnr = flit[16];
      m_idx = 1;
    end else begin
      m_idx++;
      if (m_idx - 1 == int'(m_len)) begin
        m_idx = 0;
        if (m_wnr) rsp_q.push_back(32'h0);
        else begin
          rsp_q.push_back(32'h0000_0400);
          for (int k = 0; k < 8; k++) begin
            rsp_q.push_back(rd_next);
            rd_next++;
          end
        end
      end
    end
  endtask

  task automatic drive();
    in_rdy   = rdy_rand  ? 1'($urandom_range(0, 1)) : 1'b1;
    rd_ready = sink_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    in_v     = (rsp_q.size() > 0);
    in_data  = in_v ? rsp_q[0] : '0;
    pkt_v    = (req_addr.size() > 0);
    pkt_addr = pkt_v ? req_addr[0] : '0;
    pkt_wnr  = pkt_v ? req_wnr[0] : 1'b0;
    wd_v     = (wr_idx < wr_src.size());
    wd       = wd_v ? wr_src[wr_idx] : '0;
  endtask

  // One clock: observe transfers at negedge, update stimulus after posedge
  task automatic step();
    bit took_pkt;
    @(negedge clk);
    if (stall_prev && reset_i) begin
      check("stall_v", {31'b0, out_v}, 32'd1);
      check("stall_data", out_data, stall_data);
    end
    stall_prev = reset_i && out_v && !in_rdy;
    stall_data = out_data;
    took_pkt = pkt_yumi;
    if (pkt_yumi) begin
      if (outstanding) overlap_cnt++;
      outstanding = 1;
      n_pkt++;
    end
    if (in_v && out_rdy) begin
      void'(rsp_q.pop_front());
      if (rsp_q.size() == 0) outstanding = 0;
    end
    if (out_v && in_rdy) begin
      out_q.push_back(out_data);
      model_tx(out_data);
    end
    if (wd_yumi) begin
      n_wyumi++;
      wr_idx++;
    end
    if (rd_v && rd_ready) rd_q.push_back(rd);
    if (wr_ack) n_ack++;
    @(posedge clk); #1;
    if (took_pkt) begin
      void'(req_addr.pop_front());
      void'(req_wnr.pop_front());
    end
    drive();
  endtask

  task automatic run_out(input int n);
    int k = 0;
    while (out_q.size() < n && k < 500) begin step(); k++; end
    check("out_flit_count", out_q.size(), n);
  endtask

  task automatic run_rd(input int n);
    int k = 0;
    while (rd_q.size() < n && k < 500) begin step(); k++; end
    check("rd_word_count", rd_q.size(), n);
  endtask

  task automatic run_ack(input int n);
    int k = 0;
    while (n_ack < n && k < 500) begin step(); k++; end
    check("ack_count_reach", n_ack, n);
  endtask

  task automatic clear_logs();
    out_q.delete(); rd_q.delete();
    n_pkt = 0; n_wyumi = 0; n_ack = 0;
  endtask

  task automatic load_wr(input logic [31:0] base);
    wr_src.delete();
    for (int i = 0; i < 8; i++) wr_src.push_back(base + 32'(i));
    wr_idx = 0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_link"}, wh_o[31:0], 32'h0);
    check({tag, "_link_hi"}, {30'b0, wh_o[33:32]}, 32'h0);
    check({tag, "_ctl"}, {27'b0, pkt_yumi, wd_yumi, rd_v, wr_ack, 1'b0}, 32'h0);
    check({tag, "_rdata"}, rd, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dest_cord = 7'h1F;
    my_cid    = 5'd3;
    reset_i   = 1'b0;
    wr_src.delete();
    // A request is presented during reset; it must not be accepted yet
    req_addr.push_back(32'h0000_1000); req_wnr.push_back(1'b0);
    drive();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_zero_outputs("reset");
      @(posedge clk); #1;
    end
    reset_i = 1'b1;
    drive();

    // Read on an always-ready link
    rd_next = 32'h0;
    run_out(2);
    check("rd_hdr", out_q[0], RD_HDR);
    check("rd_addr", out_q[1], 32'h0000_1000);
    check("rd_pkt_yumi", n_pkt, 1);
    run_rd(8);
    for (int i = 0; i < 8; i++) check("rd_data", rd_q[i], 32'(i));
    check("rd_no_ack", n_ack, 0);
    repeat (3) step();

    // Write on an always-ready link
    clear_logs();
    load_wr(32'hA0);
    req_addr.push_back(32'h40); req_wnr.push_back(1'b1);
    drive();
    run_out(10);
    check("wr_hdr", out_q[0], WR_HDR);
    check("wr_addr", out_q[1], 32'h40);
    for (int i = 0; i < 8; i++) check("wr_data", out_q[2+i], 32'hA0 + 32'(i));
    check("wr_yumi_count", n_wyumi, 8);
    run_ack(1);
    repeat (5) step();
    check("wr_ack_once", n_ack, 1);
    check("wr_flits_total", out_q.size(), 10);

    // Write under random link backpressure
    clear_logs();
    load_wr(32'hB0);
    rdy_rand = 1;
    req_addr.push_back(32'h80); req_wnr.push_back(1'b1);
    drive();
    run_out(10);
    check("bp_wr_hdr", out_q[0], WR_HDR);
    check("bp_wr_addr", out_q[1], 32'h80);
    for (int i = 0; i < 8; i++) check("bp_wr_data", out_q[2+i], 32'hB0 + 32'(i));
    check("bp_wr_yumi_count", n_wyumi, 8);
    run_ack(1);
    rdy_rand = 0;
    repeat (3) step();
    check("bp_wr_ack_once", n_ack, 1);

    // Read under random sink backpressure
    clear_logs();
    sink_rand = 1;
    rd_next = 32'h100;
    req_addr.push_back(32'h0000_1000); req_wnr.push_back(1'b0);
    drive();
    run_out(2);
    check("bp_rd_hdr", out_q[0], RD_HDR);
    run_rd(8);
    for (int i = 0; i < 8; i++) check("bp_rd_data", rd_q[i], 32'h100 + 32'(i));
    repeat (4) step();
    sink_rand = 0;
    check("bp_rd_no_extra", rd_q.size(), 8);

    // Back-to-back read, write, read with valid held high
    clear_logs();
    load_wr(32'hC0);
    overlap_cnt = 0;
    rd_next = 32'h200;
    req_addr.push_back(32'h100); req_wnr.push_back(1'b0);
    req_addr.push_back(32'h200); req_wnr.push_back(1'b1);
    req_addr.push_back(32'h300); req_wnr.push_back(1'b0);
    drive();
    begin
      int k = 0;
      while (!(rd_q.size() == 16 && n_ack == 1 && !outstanding) && k < 800) begin
        step(); k++;
      end
    end
    repeat (3) step();
    check("b2b_pkts", n_pkt, 3);
    check("b2b_overlap", overlap_cnt, 0);
    check("b2b_flits", out_q.size(), 14);
    check("b2b_hdr0", out_q[0], RD_HDR);
    check("b2b_hdr1", out_q[2], WR_HDR);
    check("b2b_wdata0", out_q[4], 32'hC0);
    check("b2b_hdr2", out_q[12], RD_HDR);
    check("b2b_addr2", out_q[13], 32'h300);
    check("b2b_rd_first", rd_q[0], 32'h200);
    check("b2b_rd_last", rd_q[15], 32'h20F);
    check("b2b_ack", n_ack, 1);

    // Reset in the middle of a write, after three data flits
    clear_logs();
    load_wr(32'hD0);
    req_addr.push_back(32'h500); req_wnr.push_back(1'b1);
    drive();
    run_out(5);
    check("mid_wr_yumi", n_wyumi, 3);
    reset_i = 1'b0;
    stall_prev = 0;
    drive();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_zero_outputs("midreset");
      @(posedge clk); #1;
    end
    reset_i = 1'b1;
    rsp_q.delete(); wr_src.delete(); wr_idx = 0;
    m_idx = 0; outstanding = 0;
    clear_logs();
    rd_next = 32'h300;
    req_addr.push_back(32'h600); req_wnr.push_back(1'b0);
    drive();
    run_out(2);
    check("post_rst_hdr", out_q[0], RD_HDR);
    check("post_rst_addr", out_q[1], 32'h600);
    run_rd(8);
    check("post_rst_rd0", rd_q[0], 32'h300);
    check("post_rst_rd7", rd_q[7], 32'h307);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
